// File: rtl/task_chk_pkg.sv
// Shared state/mode encodings and element-width constants for the task result checker.
package task_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  typedef enum logic {
    MODE_CMP  = 1'b0,
    MODE_TICK = 1'b1
  } mode_e;

  localparam int DW_8  = 8;
  localparam int DW_16 = 16;
  localparam int DW_32 = 32;
  localparam int DW_64 = 64;

  function automatic bit dw_legal(input int dw);
    return (dw == DW_8) || (dw == DW_16) || (dw == DW_32) || (dw == DW_64);
  endfunction

  // A 64-bit element spans two words, so a word never holds more than one of them.
  function automatic int lanes_per_word(input int dw);
    if (!dw_legal(dw)) return 1;
    return (dw == DW_64) ? 1 : DW_32 / dw;
  endfunction

endpackage

// File: rtl/popcount32.sv
// Population count of a 32-bit vector.
module popcount32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  always_comb begin
    o_count = '0;
    for (int b = 0; b < 32; b++) begin
      o_count = o_count + {5'd0, i_data[b]};
    end
  end

endmodule

// File: rtl/task_result_checker.sv
// Streams captured words against reference words (or totals their set bits) and reports pass/fail.
// state  | meaning
// IDLE   | waiting for start; last result held on pass/err_count
// RUN    | accepting words, comparing lanes and counting ticks
// FINISH | final error/len_err/pass evaluation; done pulses next cycle
module task_result_checker
  import task_chk_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TOL_MASK   = '1,
  parameter int unsigned           REF_SCALE  = 1,
  parameter int                    LEN_W      = 10,
  parameter int                    CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [LEN_W-1:0]  num_words,
  input  logic [31:0]       exp_ticks,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       cap_data,
  input  logic [31:0]       ref_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [31:0]       tick_count,
  output logic [LEN_W+1:0]  first_err_idx,
  output logic              first_err_vld,
  output logic              len_err
);

  localparam int                    LP_LANES   = lanes_per_word(DATA_WIDTH);
  localparam int                    LP_LSH     = $clog2(LP_LANES);
  localparam bit                    LP_WIDE    = (DATA_WIDTH == DW_64);
  localparam logic [DATA_WIDTH-1:0] LP_SCALE   = DATA_WIDTH'(REF_SCALE);
  localparam logic [63:0]           LP_CNT_MAX = (CNT_W >= 64) ? '1 : ((64'd1 << CNT_W) - 64'd1);

  state_e            r_state, w_state_nxt;
  mode_e             r_mode;
  logic [LEN_W-1:0]  r_num_words, r_word_idx;
  logic [31:0]       r_exp_ticks, r_cap_lo, r_ref_lo, r_tick_count;
  logic [CNT_W-1:0]  r_err_count;
  logic [LEN_W+1:0]  r_first_idx;
  logic              r_first_vld, r_pass, r_done, r_len_err;

  logic              w_accept, w_last, w_cmp_en, w_len_bad;
  logic [63:0]       w_cap_vec, w_ref_vec;
  logic [DATA_WIDTH-1:0] w_cap_el, w_ref_el;
  logic [31:0]       w_mis, w_tick_abs;
  logic [4:0]        w_first_lane;
  logic [5:0]        w_tick_pop, w_mis_cnt;
  logic [LEN_W+1:0]  w_elem_idx;
  logic [CNT_W:0]    w_err_sum;
  logic [CNT_W-1:0]  w_err_add, w_tick_sat, w_final_err;

  assign w_accept = in_valid && (r_state == RUN);
  assign w_last   = (r_word_idx == (r_num_words - LEN_W'(1)));
  // Wide elements are only complete once the odd (high) half arrives.
  assign w_cmp_en = (r_mode == MODE_CMP) && (!LP_WIDE || r_word_idx[0]);
  assign w_cap_vec = LP_WIDE ? {cap_data, r_cap_lo} : {32'd0, cap_data};
  assign w_ref_vec = LP_WIDE ? {ref_data, r_ref_lo} : {32'd0, ref_data};

  always_comb begin
    w_mis        = '0;
    w_first_lane = '0;
    w_cap_el     = '0;
    w_ref_el     = '0;
    for (int l = LP_LANES - 1; l >= 0; l--) begin
      w_cap_el = w_cap_vec[l*DATA_WIDTH +: DATA_WIDTH];
      w_ref_el = w_ref_vec[l*DATA_WIDTH +: DATA_WIDTH] * LP_SCALE;
      if ((w_cap_el & TOL_MASK) != (w_ref_el & TOL_MASK)) begin
        w_mis[l]     = 1'b1;
        w_first_lane = 5'(l);
      end
    end
  end

  popcount32 u_pop_tick (.i_data(cap_data), .o_count(w_tick_pop));
  popcount32 u_pop_mis  (.i_data(w_mis),    .o_count(w_mis_cnt));

  always_comb begin
    w_elem_idx = LP_WIDE ? (LEN_W+2)'(r_word_idx >> 1)
                         : ((LEN_W+2)'(r_word_idx) << LP_LSH) + (LEN_W+2)'(w_first_lane);
    w_err_sum  = {1'b0, r_err_count} + (CNT_W+1)'(w_mis_cnt);
    w_err_add  = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    w_tick_abs = (r_tick_count >= r_exp_ticks) ? (r_tick_count - r_exp_ticks)
                                               : (r_exp_ticks - r_tick_count);
    w_tick_sat = ({32'd0, w_tick_abs} > LP_CNT_MAX) ? '1 : CNT_W'(w_tick_abs);
    w_final_err = (r_mode == MODE_TICK) ? w_tick_sat : r_err_count;
    w_len_bad  = LP_WIDE && r_num_words[0];
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = (num_words == '0) ? FINISH : RUN;
      RUN:     if (w_accept && w_last) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode       <= MODE_CMP;
      r_num_words  <= '0;
      r_word_idx   <= '0;
      r_exp_ticks  <= '0;
      r_cap_lo     <= '0;
      r_ref_lo     <= '0;
      r_tick_count <= '0;
      r_err_count  <= '0;
      r_first_idx  <= '0;
      r_first_vld  <= 1'b0;
      r_pass       <= 1'b0;
      r_done       <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_done <= (r_state == FINISH);
      case (r_state)
        IDLE: if (start) begin
          r_mode       <= mode_e'(mode);
          r_num_words  <= num_words;
          r_exp_ticks  <= exp_ticks;
          r_word_idx   <= '0;
          r_tick_count <= '0;
          r_err_count  <= '0;
          r_first_idx  <= '0;
          r_first_vld  <= 1'b0;
          r_pass       <= 1'b0;
          r_len_err    <= 1'b0;
        end
        RUN: if (w_accept) begin
          r_word_idx   <= r_word_idx + LEN_W'(1);
          r_tick_count <= r_tick_count + 32'(w_tick_pop);
          if (LP_WIDE && !r_word_idx[0]) begin
            r_cap_lo <= cap_data;
            r_ref_lo <= ref_data;
          end
          if (w_cmp_en) begin
            r_err_count <= w_err_add;
            if ((w_mis != '0) && !r_first_vld) begin
              r_first_vld <= 1'b1;
              r_first_idx <= w_elem_idx;
            end
          end
        end
        FINISH: begin
          r_err_count <= w_final_err;
          r_len_err   <= w_len_bad;
          r_pass      <= (w_final_err == '0) && !w_len_bad;
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (r_state == RUN);
  assign busy          = (r_state == RUN) || (r_state == FINISH);
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign tick_count    = r_tick_count;
  assign first_err_idx = r_first_idx;
  assign first_err_vld = r_first_vld;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_task_result_checker.sv
// Scoreboard bench for task_result_checker: four configurations driven from shared stimulus.
module tb_task_result_checker;

  typedef struct {
    int          id;
    logic [15:0] err;
    logic [31:0] tick;
    logic        ps;
    logic        ln;
    logic        vld;
    logic [11:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  start_v = '0;
  logic        mode = 1'b0;
  logic [9:0]  num_words = '0;
  logic [31:0] exp_ticks = '0;
  logic        in_valid = 1'b0;
  logic [31:0] cap_data = '0;
  logic [31:0] ref_data = '0;

  logic [3:0]  in_ready_v, busy_v, done_v, pass_v, len_v, fvld_v;
  logic [15:0] errc  [4];
  logic [31:0] tickc [4];
  logic [11:0] fidx  [4];

  exp_t        sb[$];
  logic [31:0] wc[$];
  logic [31:0] wr[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // id 0: 16-bit lanes
  task_result_checker #(.DATA_WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .num_words(num_words),
    .exp_ticks(exp_ticks), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .cap_data(cap_data), .ref_data(ref_data), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(errc[0]), .tick_count(tickc[0]),
    .first_err_idx(fidx[0]), .first_err_vld(fvld_v[0]), .len_err(len_v[0]));

  // id 1: 64-bit elements, reference scaled by 9
  task_result_checker #(.DATA_WIDTH(64), .REF_SCALE(9)) u64 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .num_words(num_words),
    .exp_ticks(exp_ticks), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .cap_data(cap_data), .ref_data(ref_data), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(errc[1]), .tick_count(tickc[1]),
    .first_err_idx(fidx[1]), .first_err_vld(fvld_v[1]), .len_err(len_v[1]));

  // id 2: 32-bit, low 14 bits ignored
  task_result_checker #(.DATA_WIDTH(32), .TOL_MASK(32'hFFFF_C000)) u32m (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .num_words(num_words),
    .exp_ticks(exp_ticks), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .cap_data(cap_data), .ref_data(ref_data), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(errc[2]), .tick_count(tickc[2]),
    .first_err_idx(fidx[2]), .first_err_vld(fvld_v[2]), .len_err(len_v[2]));

  // id 3: defaults
  task_result_checker u32 (
    .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode), .num_words(num_words),
    .exp_ticks(exp_ticks), .in_valid(in_valid), .in_ready(in_ready_v[3]),
    .cap_data(cap_data), .ref_data(ref_data), .busy(busy_v[3]), .done(done_v[3]),
    .pass(pass_v[3]), .err_count(errc[3]), .tick_count(tickc[3]),
    .first_err_idx(fidx[3]), .first_err_vld(fvld_v[3]), .len_err(len_v[3]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic expect_res(input int id, input logic [15:0] err, input logic [31:0] tick,
                            input logic ps, input logic ln, input logic vld, input logic [11:0] idx);
    exp_t e;
    e.id = id; e.err = err; e.tick = tick; e.ps = ps; e.ln = ln; e.vld = vld; e.idx = idx;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && (done_v != 4'b0)) begin
      int   id;
      exp_t e;
      id = done_v[0] ? 0 : done_v[1] ? 1 : done_v[2] ? 2 : 3;
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(id) + 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("done_id",       64'(id),        64'(e.id));
        chk("err_count",     64'(errc[id]),  64'(e.err));
        chk("tick_count",    64'(tickc[id]), 64'(e.tick));
        chk("pass",          64'(pass_v[id]), 64'(e.ps));
        chk("len_err",       64'(len_v[id]),  64'(e.ln));
        chk("first_err_vld", 64'(fvld_v[id]), 64'(e.vld));
        if (e.vld) chk("first_err_idx", 64'(fidx[id]), 64'(e.idx));
      end
    end
  end

  task automatic send_word(input logic [31:0] c, input logic [31:0] r, input bit gaps);
    bit acc;
    int guard;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    cap_data = c;
    ref_data = r;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 20) begin
      @(negedge clk);
      acc = |in_ready_v;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_run(input int id, input logic md, input int n, input logic [31:0] et,
                        input bit gaps, input bit poke, input logic exp_pass);
    int k;
    bit seen;
    @(posedge clk); #1;
    mode      = md;
    num_words = 10'(n);
    exp_ticks = et;
    start_v[id] = 1'b1;
    @(posedge clk); #1;
    start_v[id] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (poke && i == 2) begin
        mode = ~md; num_words = 10'd1; start_v[id] = 1'b1;
        @(posedge clk); #1;
        start_v[id] = 1'b0; mode = md; num_words = 10'(n);
      end
      send_word(wc[i], wr[i], gaps);
    end
    k = 0;
    seen = 1'b0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      seen = |done_v;
    end
    chk("done_latency", 64'(k), 64'd2);
    repeat (3) @(negedge clk);
    chk("pass_hold", 64'(pass_v[id]), 64'(exp_pass));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     64'(busy_v),     64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready_v), 64'd0);
    chk({tag, "_done"},     64'(done_v),     64'd0);
    chk({tag, "_pass"},     64'(pass_v),     64'd0);
    chk({tag, "_len_err"},  64'(len_v),      64'd0);
    chk({tag, "_fvld"},     64'(fvld_v),     64'd0);
    chk({tag, "_err"},      64'(errc[3]),    64'd0);
    chk({tag, "_tick"},     64'(tickc[3]),   64'd0);
    chk({tag, "_fidx"},     64'(fidx[3]),    64'd0);
  endtask

  task automatic load(input logic [31:0] c[$], input logic [31:0] r[$]);
    wc = c;
    wr = r;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("after_reset");

    // 16-bit: word 2 upper lane differs -> element 5
    load('{32'h1111_2222, 32'h3333_4444, 32'hAAAA_6666, 32'h7777_8888},
         '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888});
    expect_res(0, 16'd1, 32'd52, 1'b0, 1'b0, 1'b1, 12'd5);
    do_run(0, 1'b0, 4, 32'd0, 1'b0, 1'b0, 1'b0);

    // 16-bit: two lanes then one lane; first index stays at element 2
    load('{32'h0, 32'h0001_0001, 32'h0}, '{32'h0, 32'h0, 32'h0000_0010});
    expect_res(0, 16'd3, 32'd2, 1'b0, 1'b0, 1'b1, 12'd2);
    do_run(0, 1'b0, 3, 32'd0, 1'b1, 1'b0, 1'b0);

    // 64-bit x9: element 1 reference overflows and truncates
    load('{32'h0000_001B, 32'h0000_0009, 32'h0000_0009, 32'h2000_0000},
         '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h2000_0000});
    expect_res(1, 16'd0, 32'd9, 1'b1, 1'b0, 1'b0, 12'd0);
    do_run(1, 1'b0, 4, 32'd0, 1'b0, 1'b0, 1'b1);

    // 64-bit: odd word count, trailing word not compared
    load('{32'h0000_001B, 32'h0000_0009, 32'h0000_000F},
         '{32'h0000_0003, 32'h0000_0001, 32'h0000_0000});
    expect_res(1, 16'd0, 32'd10, 1'b0, 1'b1, 1'b0, 12'd0);
    do_run(1, 1'b0, 3, 32'd0, 1'b0, 1'b0, 1'b0);

    // 64-bit: element 1 mismatch
    load('{32'h0000_001B, 32'h0000_0009, 32'h0, 32'h0},
         '{32'h0000_0003, 32'h0000_0001, 32'h1, 32'h0});
    expect_res(1, 16'd1, 32'd6, 1'b0, 1'b0, 1'b1, 12'd1);
    do_run(1, 1'b0, 4, 32'd0, 1'b1, 1'b0, 1'b0);

    // tolerance mask hides bits [13:0]
    load('{32'h1234_3FFF, 32'hABCD_0001}, '{32'h1234_0000, 32'hABCD_2000});
    expect_res(2, 16'd0, 32'd30, 1'b1, 1'b0, 1'b0, 12'd0);
    do_run(2, 1'b0, 2, 32'd0, 1'b0, 1'b0, 1'b1);

    // bit 14 is inside the mask
    load('{32'h0000_4000}, '{32'h0});
    expect_res(2, 16'd1, 32'd1, 1'b0, 1'b0, 1'b1, 12'd0);
    do_run(2, 1'b0, 1, 32'd0, 1'b0, 1'b0, 1'b0);

    // tick mode: 250 words, one set bit
    wc.delete();
    wr.delete();
    for (int i = 0; i < 250; i++) begin
      wc.push_back((i == 100) ? 32'h0000_0400 : 32'h0);
      wr.push_back($urandom());
    end
    expect_res(3, 16'd0, 32'd1, 1'b1, 1'b0, 1'b0, 12'd0);
    do_run(3, 1'b1, 250, 32'd1, 1'b0, 1'b0, 1'b1);
    expect_res(3, 16'd3, 32'd1, 1'b0, 1'b0, 1'b0, 12'd0);
    do_run(3, 1'b1, 250, 32'd4, 1'b1, 1'b0, 1'b0);

    // zero-length run clears the previous failing result
    expect_res(3, 16'd0, 32'd0, 1'b1, 1'b0, 1'b0, 12'd0);
    do_run(3, 1'b0, 0, 32'd0, 1'b0, 1'b0, 1'b1);

    // start pulsed mid-run with different mode/length is ignored
    load('{32'h1, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h5}, '{32'h1, 32'h3, 32'hFFFF_FFFF, 32'h0, 32'h4});
    expect_res(3, 16'd2, 32'd36, 1'b0, 1'b0, 1'b1, 12'd1);
    do_run(3, 1'b0, 5, 32'd0, 1'b1, 1'b1, 1'b0);

    // reset mid-run: everything clears, no done afterwards
    @(posedge clk); #1;
    mode = 1'b0; num_words = 10'd6; start_v[3] = 1'b1;
    @(posedge clk); #1;
    start_v[3] = 1'b0;
    send_word(32'h0000_00F0, 32'h0, 1'b1);
    send_word(32'h0000_0003, 32'h0000_0003, 1'b1);
    send_word(32'h0000_0001, 32'h0000_0002, 1'b0);
    chk("mid_run_busy", 64'(busy_v[3]), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero("mid_run_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    k = 0;
    seen = 1'b0;
    while (k < 12) begin
      @(negedge clk);
      k++;
      if (done_v != 4'b0 || busy_v != 4'b0) seen = 1'b1;
    end
    chk("no_activity_after_reset", 64'(seen), 64'd0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
